// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and registers the
// fetched word for decode. A MEM-stage redirect has priority over a stall.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall_IF,
   input  logic        redirect_MEM,
   input  logic [31:0] redirect_pc_MEM,
   output logic [31:0] IF_PC_ID,
   output logic [31:0] IF_PC4_ID,
   output logic [31:0] IF_Inst_ID,
   output logic [6:0]  IF_Op_ID,
   output logic [2:0]  IF_f3_ID,
   output logic [6:0]  IF_f7_ID,
   output logic [4:0]  IF_rs1_ID,
   output logic [4:0]  IF_rs2_ID,
   output logic [4:0]  IF_rd_ID,
   output logic        IF_valid_ID,
   output logic [31:0] fetch_cnt
);

   logic [31:0] pc_q,   pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] idpc_q, idpc_d;
   logic [31:0] idpc4_q, idpc4_d;
   logic        vld_q,  vld_d;
   logic [31:0] cnt_q,  cnt_d;
   logic [31:0] pc_plus4;

   // Sequential PC; the +4 wraps naturally at 2^32.
   assign pc_plus4 = pc_q + 32'd4;

   // Next-state selection: redirect squashes the wrong-path word even when
   // the hazard unit is stalling, otherwise stall freezes everything.
   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      idpc_d  = idpc_q;
      idpc4_d = idpc4_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      if (redirect_MEM) begin
         pc_d    = {redirect_pc_MEM[31:2], 2'b00};
         inst_d  = NOP_INST;
         idpc_d  = 32'd0;
         idpc4_d = 32'd0;
         vld_d   = 1'b0;
      end else if (!stall_IF) begin
         pc_d    = pc_plus4;
         inst_d  = imem_rdata;
         idpc_d  = pc_q;
         idpc4_d = pc_plus4;
         vld_d   = 1'b1;
         cnt_d   = cnt_q + 32'd1;
      end
   end

   // PC, IF/ID register and fetch counter with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         idpc_q  <= 32'd0;
         idpc4_q <= 32'd0;
         vld_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         idpc_q  <= idpc_d;
         idpc4_q <= idpc4_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   // Address comes straight from the PC register: no input-to-output path.
   assign imem_addr   = pc_q;
   assign IF_PC_ID    = idpc_q;
   assign IF_PC4_ID   = idpc4_q;
   assign IF_Inst_ID  = inst_q;
   assign IF_valid_ID = vld_q;
   assign fetch_cnt   = cnt_q;

   // Field outputs are plain slices of the registered word.
   assign IF_Op_ID  = inst_q[6:0];
   assign IF_f3_ID  = inst_q[14:12];
   assign IF_f7_ID  = inst_q[31:25];
   assign IF_rs1_ID = inst_q[19:15];
   assign IF_rs2_ID = inst_q[24:20];
   assign IF_rd_ID  = inst_q[11:7];

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors with hand-computed expectations pushed into
// a scoreboard queue; a monitor pops and compares on each falling edge.
module tb_if_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic [31:0] addr;
      logic [31:0] cnt;
      logic        valid;
      logic        which;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (RESET_PC = 0)
   logic        rst = 1'b1;
   logic        stall_IF = 1'b0, redirect_MEM = 1'b0;
   logic [31:0] redirect_pc_MEM = 32'd0;
   logic [31:0] imem_addr, imem_rdata, IF_PC_ID, IF_PC4_ID, IF_Inst_ID, fetch_cnt;
   logic [6:0]  IF_Op_ID, IF_f7_ID;
   logic [2:0]  IF_f3_ID;
   logic [4:0]  IF_rs1_ID, IF_rs2_ID, IF_rd_ID;
   logic        IF_valid_ID;

   // wrap instance (RESET_PC = FFFF_FFF8)
   logic        rst2 = 1'b1;
   logic        stall2 = 1'b0, redir2 = 1'b0;
   logic [31:0] rpc2 = 32'd0;
   logic [31:0] a2, rd2, pc2, pc42, inst2, cnt2;
   logic [6:0]  op2, f72;
   logic [2:0]  f32;
   logic [4:0]  rs12, rs22, rdd2;
   logic        v2;

   // imem: word = 0x13 + address, with one real instruction at 0x200
   assign imem_rdata = (imem_addr == 32'h200) ? 32'h4020_D0B3 : 32'h13 + imem_addr;
   assign rd2        = 32'h13 + a2;

   if_stage u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall_IF(stall_IF), .redirect_MEM(redirect_MEM), .redirect_pc_MEM(redirect_pc_MEM),
      .IF_PC_ID(IF_PC_ID), .IF_PC4_ID(IF_PC4_ID), .IF_Inst_ID(IF_Inst_ID),
      .IF_Op_ID(IF_Op_ID), .IF_f3_ID(IF_f3_ID), .IF_f7_ID(IF_f7_ID),
      .IF_rs1_ID(IF_rs1_ID), .IF_rs2_ID(IF_rs2_ID), .IF_rd_ID(IF_rd_ID),
      .IF_valid_ID(IF_valid_ID), .fetch_cnt(fetch_cnt));

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst2), .imem_addr(a2), .imem_rdata(rd2),
      .stall_IF(stall2), .redirect_MEM(redir2), .redirect_pc_MEM(rpc2),
      .IF_PC_ID(pc2), .IF_PC4_ID(pc42), .IF_Inst_ID(inst2),
      .IF_Op_ID(op2), .IF_f3_ID(f32), .IF_f7_ID(f72),
      .IF_rs1_ID(rs12), .IF_rs2_ID(rs22), .IF_rd_ID(rdd2),
      .IF_valid_ID(v2), .fetch_cnt(cnt2));

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic exp_t act_of(logic w);
      exp_t a;
      if (w) a = {pc2, pc42, inst2, a2, cnt2, v2, 1'b1};
      else   a = {IF_PC_ID, IF_PC4_ID, IF_Inst_ID, imem_addr, fetch_cnt, IF_valid_ID, 1'b0};
      return a;
   endfunction

   function automatic logic [31:0] fld_of(logic w);
      if (w) return {op2, f32, f72, rs12, rs22, rdd2};
      return {IF_Op_ID, IF_f3_ID, IF_f7_ID, IF_rs1_ID, IF_rs2_ID, IF_rd_ID};
   endfunction

   function automatic logic [31:0] fld_exp(logic [31:0] i);
      return {i[6:0], i[14:12], i[31:25], i[19:15], i[24:20], i[11:7]};
   endfunction

   // Compare one expected record (state + decoded fields) against the DUT.
   task automatic check(input string nm, input exp_t e);
      exp_t a;
      logic [31:0] f;
      a = act_of(e.which);
      f = fld_of(e.which);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s state: got pc=%h pc4=%h inst=%h addr=%h cnt=%0d v=%b, want pc=%h pc4=%h inst=%h addr=%h cnt=%0d v=%b",
                  nm, a.pc, a.pc4, a.inst, a.addr, a.cnt, a.valid,
                  e.pc, e.pc4, e.inst, e.addr, e.cnt, e.valid);
      end
      n_vec++;
      if (f !== fld_exp(e.inst)) begin
         n_err++;
         $display("FAIL %s fields: got %h want %h", nm, f, fld_exp(e.inst));
      end
   endtask

   // Monitor: every cycle the DUT presents a new IF/ID state; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", e);
         end
      end
   end

   // Apply one cycle of inputs and queue the state expected after that edge.
   task automatic step(input logic w, input logic st, input logic rd, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] inst,
                       input logic [31:0] addr, input logic [31:0] cnt, input logic v);
      stall_IF = st;
      redirect_MEM = rd;
      redirect_pc_MEM = tgt;
      @(posedge clk);
      #1;
      exp_q.push_back({pc, pc4, inst, addr, cnt, v, w});
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d records left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   localparam exp_t RST0 = {32'd0, 32'd0, 32'h13, 32'd0, 32'd0, 1'b0, 1'b0};

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      #1 check("reset", RST0);
      @(negedge clk) rst = 1'b0;

      // free-running fetch: w st rd tgt | pc pc4 inst addr cnt v
      step(0, 0, 0, 0, 32'h0, 32'h4, 32'h13, 32'h4, 1, 1);
      step(0, 0, 0, 0, 32'h4, 32'h8, 32'h17, 32'h8, 2, 1);
      step(0, 0, 0, 0, 32'h8, 32'hC, 32'h1B, 32'hC, 3, 1);
      // three-cycle stall with PC 8 in ID
      step(0, 1, 0, 0, 32'h8, 32'hC, 32'h1B, 32'hC, 3, 1);
      step(0, 1, 0, 0, 32'h8, 32'hC, 32'h1B, 32'hC, 3, 1);
      step(0, 1, 0, 0, 32'h8, 32'hC, 32'h1B, 32'hC, 3, 1);
      step(0, 0, 0, 0, 32'hC, 32'h10, 32'h1F, 32'h10, 4, 1);
      step(0, 0, 0, 0, 32'h10, 32'h14, 32'h23, 32'h14, 5, 1);
      // redirect to misaligned 0x103 while stalled: bubble, PC 0x100
      step(0, 1, 1, 32'h103, 32'h0, 32'h0, 32'h13, 32'h100, 5, 0);
      step(0, 0, 0, 0, 32'h100, 32'h104, 32'h113, 32'h104, 6, 1);
      // redirect held two cycles, then the sra word at 0x200
      step(0, 0, 1, 32'h200, 32'h0, 32'h0, 32'h13, 32'h200, 6, 0);
      step(0, 0, 1, 32'h200, 32'h0, 32'h0, 32'h13, 32'h200, 6, 0);
      step(0, 0, 0, 0, 32'h200, 32'h204, 32'h4020_D0B3, 32'h204, 7, 1);
      step(0, 1, 0, 0, 32'h200, 32'h204, 32'h4020_D0B3, 32'h204, 7, 1);
      drain();

      // async reset mid-cycle during a stall with fetch_cnt 7
      rst = 1'b1;
      #1 check("async_reset", RST0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0, 32'h0, 32'h4, 32'h13, 32'h4, 1, 1);
      drain();

      // wrap-around instance, main held in reset
      rst = 1'b1;
      stall_IF = 1'b0;
      @(negedge clk) rst2 = 1'b0;
      step(1, 0, 0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_000B, 32'hFFFF_FFFC, 1, 1);
      step(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000F, 32'h0000_0000, 2, 1);
      step(1, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0013, 32'h0000_0004, 3, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
